store_data_writer: RTL

STORE_DATA_WRITER -- requirements
Module: store_data_writer

---
 rtl/store_data_writer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/store_data_writer.sv
// store_data_writer
//   Sub-word store engine. Byte and halfword stores do a read-modify-write
//   of the containing word. Word stores write directly. Misaligned requests
//   are rejected with a one-cycle pulse and never reach memory.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_valid/i_addr/i_data/i_size  store request; only taken in IDLE
//   o_busy                     engine is not IDLE
//   o_done                     one-cycle pulse when the write is issued
//   o_misaligned               one-cycle pulse when a request is rejected
//   o_mem_addr                 word address (latched addr, bits [1:0] = 0)
//   o_mem_rd                   one-cycle read strobe
//   i_mem_rdata/i_mem_rvalid   read return
//   o_mem_wr/o_mem_wdata       one-cycle write strobe with merged data
module store_data_writer #(
  parameter int NBITS = 32,
  parameter int SIZE  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [NBITS-1:0] i_addr,
  input  logic [NBITS-1:0] i_data,
  input  logic [SIZE-1:0]  i_size,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_misaligned,
  output logic [NBITS-1:0] o_mem_addr,
  output logic             o_mem_rd,
  input  logic [NBITS-1:0] i_mem_rdata,
  input  logic             i_mem_rvalid,
  output logic             o_mem_wr,
  output logic [NBITS-1:0] o_mem_wdata
);

  localparam logic [SIZE-1:0] SZ_NONE = SIZE'(0);
  localparam logic [SIZE-1:0] SZ_BYTE = SIZE'(1);
  localparam logic [SIZE-1:0] SZ_HALF = SIZE'(2);
  localparam logic [SIZE-1:0] SZ_WORD = SIZE'(3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_ERR
  } state_e;

  state_e           state_q;
  logic [NBITS-1:0] addr_q;
  logic [NBITS-1:0] data_q;
  logic [SIZE-1:0]  size_q;
  logic [NBITS-1:0] rdata_q;

  // Alignment check on the incoming request, evaluated at acceptance.
  logic req_misaligned;
  always_comb begin
    req_misaligned = 1'b0;
    if (i_size == SZ_NONE)                              req_misaligned = 1'b1;
    else if (i_size == SZ_HALF && i_addr[0])            req_misaligned = 1'b1;
    else if (i_size == SZ_WORD && i_addr[1:0] != 2'b00) req_misaligned = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            addr_q <= i_addr;
            data_q <= i_data;
            size_q <= i_size;
            if (req_misaligned)        state_q <= ST_ERR;
            else if (i_size == SZ_WORD) state_q <= ST_WR;
            else                        state_q <= ST_RD;
          end
        end
        // Read data may return in the same cycle as the strobe.
        ST_RD, ST_WAIT: begin
          if (i_mem_rvalid) begin
            rdata_q <= i_mem_rdata;
            state_q <= ST_WR;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WR:   state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Little-endian merge of the right-justified store data into the read word.
  logic [NBITS-1:0] wdata_merge;
  always_comb begin
    wdata_merge = rdata_q;
    if (size_q == SZ_BYTE)
      wdata_merge[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else if (size_q == SZ_HALF)
      wdata_merge[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    else if (size_q == SZ_WORD)
      wdata_merge = data_q;
  end

  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_WR);
  assign o_misaligned = (state_q == ST_ERR);
  assign o_mem_rd     = (state_q == ST_RD);
  assign o_mem_wr     = (state_q == ST_WR);
  assign o_mem_addr   = {addr_q[NBITS-1:2], 2'b00};
  assign o_mem_wdata  = wdata_merge;

endmodule
